// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetch block.
//   - word width, PC increment, default reset PC
//   - FSM state encoding (IDLE / RUN / FLUSH)
//   - fetch_entry_t: one queue entry (fetch address + instruction word)
package inst_prefetch_pkg;

  localparam int          WORD_W       = 16;
  localparam logic [15:0] PC_INC       = 16'd2;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Instruction queue storage: circular buffer of fetch_entry_t.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (storage zeroed too)
//   i_clear      drop all entries (pointers/count only, storage untouched)
//   i_wr_en      push i_wr_data at the tail (ignored when full)
//   i_rd_en      pop the head (ignored when empty)
//   o_head       current head entry, combinational from storage
//   o_empty      no entries queued
//   o_count      number of entries queued, 0..DEPTH
// Handshake: push happens on a rising edge with i_wr_en=1 and not full,
// pop on a rising edge with i_rd_en=1 and not empty; both may happen in
// the same cycle and then count is unchanged. i_clear overrides both.
module inst_fifo
  import inst_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_wr_en,
  input  fetch_entry_t  i_wr_data,
  input  logic          i_rd_en,
  output fetch_entry_t  o_head,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr_en && !w_full;
  assign w_rd    = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // After a pop the head simply shows whatever the slot holds; that value
  // is meaningless while o_empty is set.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: issues sequential reads to instruction memory,
// queues returned words with their fetch address, and presents them to the
// control unit in program order.
// Ports:
//   CLK, CtrlRst          clock, synchronous active-low reset
//   fetch_en              allow new memory reads
//   redirect, redirect_pc one-cycle restart request and its target
//   mem_re, mem_addr      memory read request / address
//   mem_rdata             read data, valid the cycle after mem_re
//   instr_valid/ready     head handshake (consume on valid && ready)
//   instr_data, instr_pc  head word and its fetch address
//   count                 queued entries
//   state_dbg             current FSM state (ST_* encoding)
// Handshake: the control unit takes the head on a rising edge where
// instr_valid && instr_ready; instr_valid never depends on instr_ready.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [15:0] RESET_PC = RESET_PC_DEF,
  localparam int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          CtrlRst,
  input  logic          fetch_en,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  output logic          mem_re,
  output logic [15:0]   mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [15:0]   instr_data,
  output logic [15:0]   instr_pc,
  output logic [CW-1:0] count,
  output logic [1:0]    state_dbg
);

  logic [1:0]  r_state;
  logic [15:0] r_fetch_pc;
  logic        r_inflight;
  logic [15:0] r_inflight_pc;

  logic [1:0]    w_state_nxt;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wr_entry;
  logic          w_deq;
  logic          w_enq;
  logic [CW-1:0] w_occ;
  logic          w_room;
  logic          w_fetch_state;
  logic          w_issue;

  // Redirect wins over everything in its cycle: no dequeue, the word
  // arriving now is dropped, and no read is issued (its data would be stale).
  assign w_deq = CtrlRst && !redirect && !w_empty && instr_ready;
  assign w_enq = CtrlRst && !redirect && r_inflight;

  // Slots committed after this cycle: queued entries minus the one leaving,
  // plus the word still on its way back. A new read needs a free slot.
  assign w_occ  = w_count - CW'(w_deq) + CW'(r_inflight);
  assign w_room = (w_occ < CW'(DEPTH));

  assign w_fetch_state = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign w_issue       = CtrlRst && !redirect && fetch_en && w_fetch_state && w_room;

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = fetch_en ? ST_RUN : ST_IDLE;
        ST_RUN:   w_state_nxt = fetch_en ? ST_RUN : ST_IDLE;
        ST_FLUSH: w_state_nxt = fetch_en ? ST_RUN : ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
      end
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_INC;
      end
    end
  end

  assign w_wr_entry.pc   = r_inflight_pc;
  assign w_wr_entry.data = mem_rdata;

  inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (CtrlRst),
    .i_clear  (redirect),
    .i_wr_en  (w_enq),
    .i_wr_data(w_wr_entry),
    .i_rd_en  (w_deq),
    .o_head   (w_head),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  assign mem_re      = w_issue;
  assign mem_addr    = r_fetch_pc;
  assign instr_valid = !w_empty;
  assign instr_data  = w_head.data;
  assign instr_pc    = w_head.pc;
  assign count       = w_count;
  assign state_dbg   = r_state;

endmodule
